// File: rtl/dcls_error_manager_if.sv
// Configuration register bus between software and the DCLS error manager.
// The slave modport is the error manager; the master modport is whoever drives
// register accesses (CPU bridge or testbench).
interface dcls_error_manager_if;
  logic        cfg_wr_i;
  logic        cfg_rd_i;
  logic [2:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic [31:0] cfg_rdata_o;

  modport master (
    output cfg_wr_i,
    output cfg_rd_i,
    output cfg_addr_i,
    output cfg_wdata_i,
    input  cfg_rdata_o
  );

  modport slave (
    input  cfg_wr_i,
    input  cfg_rd_i,
    input  cfg_addr_i,
    input  cfg_wdata_i,
    output cfg_rdata_o
  );
endinterface

// File: rtl/dcls_error_manager.sv
// DCLS error manager: latches comparator syndromes, raises an interrupt,
// escalates to a core-pair reset request on missing acknowledge and re-arms
// the comparator through a two-cycle clear pulse.
//
// state | meaning
// IDLE  | waiting for a comparator error or rail disagreement
// ALARM | irq raised, timeout running until software acknowledges
// FAULT | timeout expired, irq and core-pair reset request held until ack
// CLEAR | comparator clears driven for two cycles, inputs ignored
module dcls_error_manager #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dcls_comparator_error_0_i,
  input  logic                dcls_comparator_error_1_i,
  input  logic [31:0]         dcls_comparator_error_vector_0_i,
  input  logic [31:0]         dcls_comparator_error_vector_1_i,
  output logic                dcls_comparator_clear_0_o,
  output logic                dcls_comparator_clear_1_o,
  dcls_error_manager_if.slave cfg,
  output logic                irq_o,
  output logic                fault_reset_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALARM = 2'd1,
    S_FAULT = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  localparam logic [15:0]      TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [2:0] A_STATUS    = 3'd0;
  localparam logic [2:0] A_FIRST_VEC = 3'd1;
  localparam logic [2:0] A_ACCUM_VEC = 3'd2;
  localparam logic [2:0] A_ERR_COUNT = 3'd3;
  localparam logic [2:0] A_CTRL      = 3'd4;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [15:0]      r_to_cnt;
  logic             r_clr_cnt;
  logic [31:0]      r_first_vec;
  logic [31:0]      r_accum_vec;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_rail_fault;
  logic             r_enable;
  logic [31:0]      r_rdata;

  logic        w_err;
  logic [31:0] w_vec;
  logic        w_rail_mis;
  logic        w_trig;
  logic        w_ctrl_wr;
  logic        w_ack;
  logic        w_wipe;
  logic        w_sample;
  logic        w_enter_alarm;
  logic        w_to_expired;
  logic [31:0] w_rd_mux;
  logic        w_unused_wdata;

  assign w_err      = dcls_comparator_error_0_i | dcls_comparator_error_1_i;
  assign w_vec      = dcls_comparator_error_vector_0_i | dcls_comparator_error_vector_1_i;
  assign w_rail_mis = (dcls_comparator_error_0_i != dcls_comparator_error_1_i) ||
                      (dcls_comparator_error_vector_0_i != dcls_comparator_error_vector_1_i);
  assign w_trig     = w_err | w_rail_mis;

  assign w_ctrl_wr      = cfg.cfg_wr_i && (cfg.cfg_addr_i == A_CTRL);
  assign w_ack          = w_ctrl_wr & cfg.cfg_wdata_i[0];
  assign w_wipe         = w_ctrl_wr & cfg.cfg_wdata_i[2];
  assign w_unused_wdata = ^cfg.cfg_wdata_i[31:3];

  // Comparator outputs are still settling while clears are driven, so ignore them.
  assign w_sample      = (r_state != S_CLEAR);
  assign w_enter_alarm = (r_state == S_IDLE) && w_trig && r_enable;
  assign w_to_expired  = (r_to_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode; ack takes priority over timeout expiry
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_enter_alarm) w_state_nxt = S_ALARM;
      S_ALARM: begin
        if (w_ack)             w_state_nxt = S_CLEAR;
        else if (w_to_expired) w_state_nxt = S_FAULT;
      end
      S_FAULT: if (w_ack)     w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_clr_cnt) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode straight from the state register
  always_comb begin
    irq_o                     = 1'b0;
    fault_reset_o             = 1'b0;
    dcls_comparator_clear_0_o = 1'b0;
    dcls_comparator_clear_1_o = 1'b0;
    case (r_state)
      S_ALARM: irq_o = 1'b1;
      S_FAULT: begin
        irq_o         = 1'b1;
        fault_reset_o = 1'b1;
      end
      S_CLEAR: begin
        dcls_comparator_clear_0_o = 1'b1;
        dcls_comparator_clear_1_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Timeout counter: restarts on ALARM entry, advances each un-acked ALARM cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
    end else if (w_enter_alarm) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_ALARM) && !w_ack && !w_to_expired) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  // Two-cycle CLEAR duration
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  r_clr_cnt <= 1'b0;
    else if (r_state == S_CLEAR)  r_clr_cnt <= ~r_clr_cnt;
    else                          r_clr_cnt <= 1'b0;
  end

  // Syndrome capture, error counting and control bits; wipe beats any update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_first_vec  <= '0;
      r_accum_vec  <= '0;
      r_err_cnt    <= '0;
      r_rail_fault <= 1'b0;
      r_enable     <= 1'b1;
    end else begin
      if (w_enter_alarm) r_first_vec <= w_vec;

      if (w_wipe)        r_accum_vec <= '0;
      else if (w_sample) r_accum_vec <= r_accum_vec | w_vec;

      if (w_wipe)                      r_rail_fault <= 1'b0;
      else if (w_sample && w_rail_mis) r_rail_fault <= 1'b1;

      if (w_wipe)                                    r_err_cnt <= '0;
      else if (w_enter_alarm && r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);

      if (w_ctrl_wr) r_enable <= cfg.cfg_wdata_i[1];
    end
  end

  // Read mux; CTRL and unmapped addresses read as zero
  always_comb begin
    w_rd_mux = '0;
    case (cfg.cfg_addr_i)
      A_STATUS:    w_rd_mux = {28'd0, r_enable, r_rail_fault, r_state};
      A_FIRST_VEC: w_rd_mux = r_first_vec;
      A_ACCUM_VEC: w_rd_mux = r_accum_vec;
      A_ERR_COUNT: w_rd_mux = 32'(r_err_cnt);
      default:     w_rd_mux = '0;
    endcase
  end

  // Registered read data, held until the next read; sees pre-write values
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           r_rdata <= '0;
    else if (cfg.cfg_rd_i) r_rdata <= w_rd_mux;
  end

  assign cfg.cfg_rdata_o = r_rdata;

endmodule

// File: tb/tb_dcls_error_manager.sv
// Directed testbench for dcls_error_manager (TIMEOUT_CYCLES=4, CNT_W=2).
module tb_dcls_error_manager;

  logic        clk_i;
  logic        rst_ni;
  logic        e0, e1;
  logic [31:0] v0, v1;
  logic        clr0, clr1;
  logic        irq_o, fault_reset_o;

  int n_chk  = 0;
  int n_fail = 0;

  dcls_error_manager_if u_if ();

  dcls_error_manager #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (2)
  ) u_dut (
    .clk_i                            (clk_i),
    .rst_ni                           (rst_ni),
    .dcls_comparator_error_0_i        (e0),
    .dcls_comparator_error_1_i        (e1),
    .dcls_comparator_error_vector_0_i (v0),
    .dcls_comparator_error_vector_1_i (v1),
    .dcls_comparator_clear_0_o        (clr0),
    .dcls_comparator_clear_1_o        (clr1),
    .cfg                              (u_if),
    .irq_o                            (irq_o),
    .fault_reset_o                    (fault_reset_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        e0, e1;
    logic [31:0] v0, v1;
    logic        wr, rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        irq, flt, clr;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic a_e0, input logic a_e1, input logic [31:0] a_v0,
                     input logic [31:0] a_v1, input logic a_wr, input logic a_rd,
                     input logic [2:0] a_addr, input logic [31:0] a_wdata,
                     input logic x_irq, input logic x_flt, input logic x_clr,
                     input logic [31:0] x_rdata);
    vec_t v;
    v.e0 = a_e0; v.e1 = a_e1; v.v0 = a_v0; v.v1 = a_v1;
    v.wr = a_wr; v.rd = a_rd; v.addr = a_addr; v.wdata = a_wdata;
    v.irq = x_irq; v.flt = x_flt; v.clr = x_clr; v.rdata = x_rdata;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic a_e0, input logic a_e1, input logic [31:0] a_v0,
                     input logic [31:0] a_v1, input logic a_wr, input logic a_rd,
                     input logic [2:0] a_addr, input logic [31:0] a_wdata);
    @(negedge clk_i);
    e0 = a_e0; e1 = a_e1; v0 = a_v0; v1 = a_v1;
    u_if.cfg_wr_i = a_wr; u_if.cfg_rd_i = a_rd;
    u_if.cfg_addr_i = a_addr; u_if.cfg_wdata_i = a_wdata;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 3'd0, 0);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(0, 0, 0, 0, 0, 1, a, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(0, 0, 0, 0, 1, 0, a, d);
  endtask

  task automatic chk_outs(input string tag, input logic x_irq, input logic x_flt,
                          input logic x_clr);
    chk({tag, "_irq"},  32'(irq_o),         32'(x_irq));
    chk({tag, "_flt"},  32'(fault_reset_o), 32'(x_flt));
    chk({tag, "_clr0"}, 32'(clr0),          32'(x_clr));
    chk({tag, "_clr1"}, 32'(clr1),          32'(x_clr));
  endtask

  initial begin
    rst_ni = 1'b0;
    e0 = 0; e1 = 0; v0 = 0; v1 = 0;
    u_if.cfg_wr_i = 0; u_if.cfg_rd_i = 0; u_if.cfg_addr_i = 0; u_if.cfg_wdata_i = 0;

    //     e0 e1 v0         v1         wr rd addr wdata | irq flt clr rdata
    // single mismatch, then timeout escalation and ack
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   0, 0, 0, 32'h8);
    add(1, 1, 32'h1001,   32'h1001,   0, 0, 3'd0, 0,   1, 0, 0, 32'h8);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   1, 0, 0, 32'h9);
    add(0, 0, 0,          0,          0, 1, 3'd1, 0,   1, 0, 0, 32'h1001);
    add(0, 0, 0,          0,          0, 1, 3'd3, 0,   1, 0, 0, 32'h1);
    add(0, 0, 0,          0,          0, 1, 3'd2, 0,   1, 1, 0, 32'h1001);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   1, 1, 0, 32'hA);
    add(0, 0, 0,          0,          1, 0, 3'd4, 3,   0, 0, 1, 32'hA);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   0, 0, 1, 32'hB);
    add(0, 0, 0,          0,          0, 0, 3'd0, 0,   0, 0, 0, 32'hB);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   0, 0, 0, 32'h8);
    // rail disagreement, ack, wipe
    add(1, 0, 32'h4,      0,          0, 0, 3'd0, 0,   1, 0, 0, 32'h8);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   1, 0, 0, 32'hD);
    add(0, 0, 0,          0,          0, 1, 3'd1, 0,   1, 0, 0, 32'h4);
    add(0, 0, 0,          0,          1, 0, 3'd4, 3,   0, 0, 1, 32'h4);
    add(0, 0, 0,          0,          1, 0, 3'd4, 6,   0, 0, 1, 32'h4);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   0, 0, 0, 32'hB);
    add(0, 0, 0,          0,          0, 1, 3'd3, 0,   0, 0, 0, 32'h0);
    add(0, 0, 0,          0,          0, 1, 3'd2, 0,   0, 0, 0, 32'h0);
    // unmapped addresses and CTRL read back zero, writes to them ignored
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   0, 0, 0, 32'h8);
    add(0, 0, 0,          0,          1, 0, 3'd5, 1,   0, 0, 0, 32'h8);
    add(0, 0, 0,          0,          0, 1, 3'd5, 0,   0, 0, 0, 32'h0);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   0, 0, 0, 32'h8);
    add(0, 0, 0,          0,          0, 1, 3'd4, 0,   0, 0, 0, 32'h0);
    // disabled: accumulates but never alarms
    add(0, 0, 0,          0,          1, 0, 3'd4, 0,   0, 0, 0, 32'h0);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   0, 0, 0, 32'h0);
    add(1, 1, 32'h8,      32'h8,      0, 0, 3'd0, 0,   0, 0, 0, 32'h0);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   0, 0, 0, 32'h0);
    add(0, 0, 0,          0,          0, 1, 3'd2, 0,   0, 0, 0, 32'h8);
    add(0, 0, 0,          0,          1, 0, 3'd4, 2,   0, 0, 0, 32'h8);
    add(0, 0, 0,          0,          0, 1, 3'd0, 0,   0, 0, 0, 32'h8);

    // reset values
    #12;
    chk_outs("rst", 0, 0, 0);
    chk("rst_rdata", u_if.cfg_rdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].e0, tbl[i].e1, tbl[i].v0, tbl[i].v1,
          tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
      chk_outs($sformatf("v%0d", i), tbl[i].irq, tbl[i].flt, tbl[i].clr);
      chk($sformatf("v%0d_rdata", i), u_if.cfg_rdata_o, tbl[i].rdata);
    end

    // ack races timeout expiry; errors held through CLEAR are ignored
    cyc(1, 1, 32'h20, 32'h20, 0, 0, 3'd0, 0);
    chk_outs("race_trig", 1, 0, 0);
    idle(); idle(); idle();
    chk_outs("race_pre", 1, 0, 0);
    wr(3'd4, 3);
    chk_outs("race_ack", 0, 0, 1);
    cyc(1, 1, 32'h40, 32'h40, 0, 0, 3'd0, 0);
    chk_outs("race_clr2", 0, 0, 1);
    cyc(1, 1, 32'h40, 32'h40, 0, 0, 3'd0, 0);
    chk_outs("race_idle", 0, 0, 0);
    cyc(1, 1, 32'h40, 32'h40, 0, 1, 3'd2, 0);
    chk_outs("race_rearm", 1, 0, 0);
    chk("race_accum", u_if.cfg_rdata_o, 32'h28);
    rd(3'd1);
    chk("race_first", u_if.cfg_rdata_o, 32'h40);
    rd(3'd3);
    chk("race_count", u_if.cfg_rdata_o, 32'h2);
    wr(3'd4, 3); idle(); idle();
    rd(3'd0);
    chk("race_status", u_if.cfg_rdata_o, 32'h8);

    // counter saturation at 3 with CNT_W=2
    wr(3'd4, 6);
    for (int n = 0; n < 4; n++) begin
      cyc(1, 1, 32'h1, 32'h1, 0, 0, 3'd0, 0);
      chk($sformatf("sat_irq%0d", n), 32'(irq_o), 32'h1);
      wr(3'd4, 3); idle(); idle();
    end
    rd(3'd3);
    chk("sat_count", u_if.cfg_rdata_o, 32'h3);

    // asynchronous reset while in FAULT
    cyc(1, 1, 32'h2, 32'h2, 0, 0, 3'd0, 0);
    idle(); idle(); idle(); idle();
    chk_outs("arst_pre", 1, 1, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_outs("arst", 0, 0, 0);
    chk("arst_rdata", u_if.cfg_rdata_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd(3'd0);
    chk("arst_status", u_if.cfg_rdata_o, 32'h8);
    rd(3'd1);
    chk("arst_first", u_if.cfg_rdata_o, 32'h0);
    rd(3'd2);
    chk("arst_accum", u_if.cfg_rdata_o, 32'h0);
    rd(3'd3);
    chk("arst_count", u_if.cfg_rdata_o, 32'h0);

    // asynchronous reset while clears are driven
    cyc(1, 1, 32'h1, 32'h1, 0, 0, 3'd0, 0);
    wr(3'd4, 3);
    chk_outs("arst2_pre", 0, 0, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_outs("arst2", 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd(3'd0);
    chk("arst2_status", u_if.cfg_rdata_o, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcls_error_manager.md
# dcls_error_manager

Error-handling stage downstream of the DCLS lockstep comparator. Consumes the comparator's two redundant error flags and error vectors, and latches first and accumulated fault syndromes. It raises an interrupt, escalates to a core-pair reset request if software does not acknowledge in time, and drives the comparator's clear inputs to re-arm it.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: cycles spent in ALARM without acknowledge before escalation to FAULT; legal range 1 to 2^16-1.
- CNT_W, 16: width of the saturating error-event counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- dcls_comparator_error_0_i  in  1  comparator error flag, rail 0.
- dcls_comparator_error_1_i  in  1  comparator error flag, rail 1.
- dcls_comparator_error_vector_0_i  in  32  error syndrome, rail 0.
- dcls_comparator_error_vector_1_i  in  32  error syndrome, rail 1.
- dcls_comparator_clear_0_o  out  1  clear to comparator, rail 0.
- dcls_comparator_clear_1_o  out  1  clear to comparator, rail 1.
- cfg_wr_i  in  1  register write strobe.
- cfg_rd_i  in  1  register read strobe.
- cfg_addr_i  in  3  register index.
- cfg_wdata_i  in  32  write data.
- cfg_rdata_o  out  32  read data, registered.
- irq_o  out  1  mismatch interrupt.
- fault_reset_o  out  1  core-pair reset request.

## Operation
- Register map:
  - 0 STATUS (RO): [1:0] state (IDLE=0, ALARM=1, FAULT=2, CLEAR=3); [2] rail_fault (sticky); [3] enable.
  - 1 FIRST_VEC (RO).
  - 2 ACCUM_VEC (RO).
  - 3 ERR_COUNT (RO), zero-extended to 32 bits.
  - 4 CTRL (WO, reads 0): bit0 ack; bit1 enable (reset value 1); bit2 wipe (clears ERR_COUNT, ACCUM_VEC and rail_fault).
  - Addresses 5-7 read 0; writes to them are ignored.
- Definitions:
  - err = error_0_i | error_1_i.
  - vec = vector_0_i | vector_1_i.
  - rail_mis = (error_0_i != error_1_i) or (vector_0_i != vector_1_i).
  - trig = err | rail_mis.
- Input sampling, every edge where state != CLEAR:
  - ACCUM_VEC |= vec.
  - rail_mis sets rail_fault.
  - In CLEAR, all inputs are ignored.
- State transitions:
  - IDLE: trig & enable → ALARM. On the same edge: FIRST_VEC <= vec, ERR_COUNT += 1 (saturating at 2^CNT_W-1), timeout counter <= 0. With enable=0, state stays IDLE, but ACCUM_VEC and rail_fault still update.
  - ALARM: ack → CLEAR. Otherwise the timeout counter increments; at value TIMEOUT_CYCLES-1 → FAULT.
  - FAULT: ack → CLEAR. Otherwise hold.
  - CLEAR: lasts exactly 2 cycles, then IDLE. A new trig can only re-enter ALARM from IDLE.
- Outputs:
  - irq_o = 1 in ALARM and FAULT.
  - fault_reset_o = 1 in FAULT.
  - Both clear outputs = 1 in CLEAR.
  - All outputs are registered (decoded from the state register).
- Register writes:
  - ack in IDLE or CLEAR: no effect.
  - Ack and timeout expiry on the same edge: ack wins, next state is CLEAR.
  - wipe and an ERR_COUNT increment on the same edge: wipe wins, count = 0.

## Timing
- Reset values:
  - State IDLE, enable = 1.
  - All outputs 0, including cfg_rdata_o.
  - FIRST_VEC, ACCUM_VEC, ERR_COUNT, rail_fault and the timeout counter all 0.
- Reset is asynchronous. Asserting it mid-operation returns to reset values immediately, including dropping fault_reset_o and the clears.
- Trigger latency: trig sampled at edge k → irq_o high after edge k (observable in cycle k+1).
- Escalation: FAULT is entered at edge k+TIMEOUT_CYCLES.
- Acknowledge: ack written at edge a → clears high during cycles a+1 and a+2, irq_o low from a+1, state IDLE after edge a+2.
- Clears are held for 2 cycles so the comparator's registered outputs have settled to 0 before sampling resumes.
- Reads: cfg_rd_i at edge r → cfg_rdata_o valid after edge r and held until the next read. A read and a write on the same edge return the pre-write value.

## Test plan
- Single mismatch: both rails error=1, vec=0x0000_1001 for one cycle → STATUS=ALARM (1), FIRST_VEC=0x1001, ERR_COUNT=1, irq_o=1 next cycle, rail_fault=0.
- Timeout: TIMEOUT_CYCLES=4, no ack → fault_reset_o rises exactly 4 cycles after ALARM entry. Then ack → clears high for 2 cycles, fault_reset_o and irq_o drop, STATUS=0.
- Rail disagreement: error_0=1, error_1=0, vectors 0x4 vs 0x0 → ALARM, rail_fault=1, FIRST_VEC=0x4. Ack then wipe → rail_fault=0, ERR_COUNT=0, ACCUM_VEC=0.
- Ack/timeout race: ack on the same edge as expiry → CLEAR (never FAULT, fault_reset_o stays 0). Inputs held at error during CLEAR do not update ACCUM_VEC. ALARM is re-entered on the first IDLE cycle.
- Disable and saturation: enable=0 with vec=0x8 → state IDLE, irq_o=0, ACCUM_VEC=0x8. With CNT_W=2, four trigger/ack cycles → ERR_COUNT=3.
- Asynchronous reset: assert rst_ni low while in FAULT → fault_reset_o, irq_o and clears go 0 without waiting for a clock edge; all registers read back their reset values.
